tl_phase_ctrl: RTL and testbench

TL_PHASE_CTRL -- requirements
Module: tl_phase_ctrl

---
 rtl/tl_phase_ctrl.sv | 141 ++++++++++++++
 tb/tb_tl_phase_ctrl.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/tl_phase_ctrl.sv
// Round-robin traffic-light phase controller with demand latching,
// rest-in-green (when RECALL=0) and a night flashing mode.
module tl_phase_ctrl #(
    parameter int N_PHASES = 4,
    parameter int T_WIDTH  = 8,
    parameter int G_TIME   = 8,
    parameter int Y_TIME   = 3,
    parameter int R_TIME   = 2,
    parameter int F_TIME   = 4,
    parameter int RECALL   = 1,
    localparam int PW      = $clog2(N_PHASES)
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic [N_PHASES-1:0] i_demand,
    input  logic                i_flash,
    output logic [PW-1:0]       o_phase,
    output logic [1:0]          o_light,
    output logic [T_WIDTH-1:0]  o_remaining,
    output logic [N_PHASES-1:0] o_pending
);

    typedef enum logic [2:0] {
        ST_START,
        ST_GREEN,
        ST_YELLOW,
        ST_ALLRED,
        ST_FLASH
    } state_t;

    localparam logic [1:0] L_RED   = 2'b00;
    localparam logic [1:0] L_GREEN = 2'b01;
    localparam logic [1:0] L_YEL   = 2'b10;
    localparam logic [1:0] L_FLASH = 2'b11;

    localparam logic [T_WIDTH-1:0] G_LOAD = T_WIDTH'(G_TIME - 1);
    localparam logic [T_WIDTH-1:0] Y_LOAD = T_WIDTH'(Y_TIME - 1);
    localparam logic [T_WIDTH-1:0] R_LOAD = T_WIDTH'(R_TIME - 1);
    localparam logic [T_WIDTH-1:0] F_LOAD = T_WIDTH'(F_TIME - 1);

    state_t               state;
    logic [T_WIDTH-1:0]   cnt;
    logic [N_PHASES-1:0]  dem_mask;
    logic [N_PHASES-1:0]  pend_nxt;
    logic [N_PHASES-1:0]  tgt_mask;
    logic                 others;
    logic                 found;
    logic [PW-1:0]        next_phase;
    logic [PW-1:0]        green_tgt;
    int                   idx;

    assign o_remaining = cnt;

    // Demand merge, next-phase search and green target selection
    always_comb begin
        dem_mask = i_demand;
        // the phase currently holding green cannot re-request itself
        if (state == ST_GREEN) dem_mask[o_phase] = 1'b0;
        pend_nxt   = o_pending | dem_mask;
        others     = |(o_pending & ~(N_PHASES'(1) << o_phase));
        next_phase = (o_phase == PW'(N_PHASES - 1)) ? '0 : o_phase + 1'b1;
        found      = 1'b0;
        idx        = 0;
        if (RECALL == 0) begin
            for (int k = 1; k < N_PHASES; k++) begin
                idx = int'(o_phase) + k;
                if (idx >= N_PHASES) idx = idx - N_PHASES;
                if (!found && o_pending[idx[PW-1:0]]) begin
                    next_phase = idx[PW-1:0];
                    found      = 1'b1;
                end
            end
        end
        // START always restarts the cycle at phase 0
        green_tgt = (state == ST_START) ? '0 : next_phase;
        tgt_mask  = N_PHASES'(1) << green_tgt;
    end

    // Phase sequencer: single shared down-counter, exit evaluated at zero
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= ST_START;
            o_phase   <= '0;
            o_light   <= L_RED;
            cnt       <= R_LOAD;
            o_pending <= '0;
        end else begin
            o_pending <= pend_nxt;
            if (cnt != '0) begin
                cnt <= cnt - 1'b1;
            end else begin
                case (state)
                    ST_START, ST_ALLRED: begin
                        if (i_flash) begin
                            state   <= ST_FLASH;
                            o_light <= L_FLASH;
                            cnt     <= F_LOAD;
                        end else begin
                            state     <= ST_GREEN;
                            o_phase   <= green_tgt;
                            o_light   <= L_GREEN;
                            cnt       <= G_LOAD;
                            // entering phase wins over a coincident request
                            o_pending <= pend_nxt & ~tgt_mask;
                        end
                    end
                    ST_GREEN: begin
                        if (RECALL == 0 && !others) begin
                            cnt <= G_LOAD;
                        end else begin
                            state   <= ST_YELLOW;
                            o_light <= L_YEL;
                            cnt     <= Y_LOAD;
                        end
                    end
                    ST_YELLOW: begin
                        state   <= ST_ALLRED;
                        o_light <= L_RED;
                        cnt     <= R_LOAD;
                    end
                    ST_FLASH: begin
                        if (!i_flash) begin
                            state   <= ST_START;
                            o_light <= L_RED;
                            cnt     <= R_LOAD;
                        end else begin
                            o_light <= (o_light == L_FLASH) ? L_RED : L_FLASH;
                            cnt     <= F_LOAD;
                        end
                    end
                    default: begin
                        state   <= ST_START;
                        o_light <= L_RED;
                        cnt     <= R_LOAD;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tl_phase_ctrl.sv
// Directed bench for tl_phase_ctrl: one RECALL=1 and one RECALL=0 instance.
module tb_tl_phase_ctrl;

    logic       clk;
    logic       rst_a, rst_b;
    logic [2:0] dem_a, dem_b;
    logic       fl_a, fl_b;
    logic [1:0] ph_a, ph_b, lt_a, lt_b;
    logic [7:0] rem_a, rem_b;
    logic [2:0] pend_a, pend_b;

    int         n_cmp = 0;
    int         n_err = 0;
    logic [2:0] exp_pend;
    logic [2:0] d;
    int         p;

    tl_phase_ctrl #(.N_PHASES(3), .T_WIDTH(8), .G_TIME(5), .Y_TIME(2),
                    .R_TIME(1), .F_TIME(2), .RECALL(1)) u_a (
        .i_clk(clk), .i_rst_n(rst_a), .i_demand(dem_a), .i_flash(fl_a),
        .o_phase(ph_a), .o_light(lt_a), .o_remaining(rem_a), .o_pending(pend_a)
    );

    tl_phase_ctrl #(.N_PHASES(3), .T_WIDTH(8), .G_TIME(5), .Y_TIME(2),
                    .R_TIME(1), .F_TIME(2), .RECALL(0)) u_b (
        .i_clk(clk), .i_rst_n(rst_b), .i_demand(dem_b), .i_flash(fl_b),
        .o_phase(ph_b), .o_light(lt_b), .o_remaining(rem_b), .o_pending(pend_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected summary");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cka(input string tag, input int eph, input int elt, input int erem);
        chk({tag, ".phase_a"}, 32'(ph_a), eph);
        chk({tag, ".light_a"}, 32'(lt_a), elt);
        chk({tag, ".rem_a"}, 32'(rem_a), erem);
    endtask

    task automatic ckb(input string tag, input int eph, input int elt, input int erem);
        chk({tag, ".phase_b"}, 32'(ph_b), eph);
        chk({tag, ".light_b"}, 32'(lt_b), elt);
        chk({tag, ".rem_b"}, 32'(rem_b), erem);
    endtask

    task automatic stepa(input logic [2:0] dv);
        dem_a = dv;
        @(posedge clk);
        #1;
        dem_a = '0;
    endtask

    task automatic stepb(input logic [2:0] dv);
        dem_b = dv;
        @(posedge clk);
        #1;
        dem_b = '0;
    endtask

    initial begin
        rst_a = 1'b0; rst_b = 1'b0;
        dem_a = '0;   dem_b = '0;
        fl_a  = 1'b0; fl_b  = 1'b0;
        exp_pend = '0;
        repeat (2) @(posedge clk);
        #1;
        cka("reset", 0, 0, 0);
        chk("reset.pend_a", 32'(pend_a), 0);
        rst_a = 1'b1;
        #1;
        cka("start", 0, 0, 0);

        // Round robin 0,1,2,0 with demand latching and coincident-entry demand
        for (int c = 0; c < 4; c++) begin
            p = c % 3;
            for (int g = 0; g < 5; g++) begin
                d = '0;
                if (c == 0 && g == 2) d = 3'b100;
                if (c == 1 && g < 2)  d = 3'b010;
                stepa(d);
                if (c == 0 && g == 2) exp_pend = 3'b100;
                if (c == 2 && g == 0) exp_pend = 3'b000;
                cka($sformatf("grn c%0d g%0d", c, g), p, 1, 4 - g);
                chk($sformatf("pend c%0d g%0d", c, g), 32'(pend_a), 32'(exp_pend));
            end
            for (int y = 0; y < 2; y++) begin
                stepa('0);
                cka($sformatf("yel c%0d y%0d", c, y), p, 2, 1 - y);
            end
            stepa('0);
            cka($sformatf("ared c%0d", c), p, 0, 0);
        end

        // Flash requested mid-green: yellow and all-red still complete
        stepa('0);
        cka("fg0", 1, 1, 4);
        fl_a = 1'b1;
        for (int g = 1; g < 5; g++) begin
            stepa('0);
            cka($sformatf("fg%0d", g), 1, 1, 4 - g);
        end
        stepa('0); cka("fy0", 1, 2, 1);
        stepa('0); cka("fy1", 1, 2, 0);
        stepa('0); cka("far", 1, 0, 0);
        stepa('0); cka("fl0", 1, 3, 1);
        stepa('0); cka("fl1", 1, 3, 0);
        stepa(3'b010); cka("fl2", 1, 0, 1);
        chk("fl2.pend", 32'(pend_a), 32'(3'b010));
        fl_a = 1'b0;
        stepa('0); cka("fl3", 1, 0, 0);
        stepa('0);
        chk("fst.light", 32'(lt_a), 0);
        chk("fst.rem", 32'(rem_a), 0);
        stepa('0); cka("fgrn", 0, 1, 4);
        chk("fgrn.pend", 32'(pend_a), 32'(3'b010));

        // Async reset mid-yellow of phase 1
        for (int g = 1; g < 5; g++) stepa('0);
        cka("r0g", 0, 1, 0);
        stepa('0); stepa('0); stepa('0);
        stepa('0); cka("r1g", 1, 1, 4);
        chk("r1g.pend", 32'(pend_a), 0);
        stepa(3'b100);
        chk("r1g.pend2", 32'(pend_a), 32'(3'b100));
        stepa('0); stepa('0); stepa('0);
        stepa('0); cka("r1y", 1, 2, 1);
        rst_a = 1'b0;
        #2;
        cka("rasync", 0, 0, 0);
        chk("rasync.pend", 32'(pend_a), 0);
        @(posedge clk);
        #1;
        rst_a = 1'b1;
        #1;
        cka("rstart", 0, 0, 0);
        stepa('0);
        cka("rgrn", 0, 1, 4);

        // RECALL=0: rest in green, then demand skips phase 1
        rst_b = 1'b1;
        #1;
        ckb("bstart", 0, 0, 0);
        for (int k = 0; k < 12; k++) begin
            stepb('0);
            ckb($sformatf("rest k%0d", k), 0, 1, 4 - (k % 5));
        end
        stepb(3'b100);
        ckb("bd0", 0, 1, 2);
        chk("bd0.pend", 32'(pend_b), 32'(3'b100));
        stepb('0); ckb("bd1", 0, 1, 1);
        stepb('0); ckb("bd2", 0, 1, 0);
        stepb('0); ckb("by0", 0, 2, 1);
        stepb('0); ckb("by1", 0, 2, 0);
        stepb('0); ckb("bar", 0, 0, 0);
        chk("bar.pend", 32'(pend_b), 32'(3'b100));
        stepb('0); ckb("bg2", 2, 1, 4);
        chk("bg2.pend", 32'(pend_b), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
